// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a leading-zero blanking mask.
// One conversion takes 2*BIN_W+2 cycles; a start in the done cycle is accepted.
module bin_to_bcd_seq #(
   parameter int unsigned BIN_W  = 9,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ADJUST = 4'b0010,
      SHIFT  = 4'b0100,
      FIN    = 4'b1000
   } state_t;

   state_t             state, state_n;
   logic [SR_W-1:0]    sr, sr_n, sr_adj;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               busy_n, done_n;
   logic [BCD_W-1:0]   bcd_n;
   logic [DIGITS-1:0]  blank_n, blank_c;

   // Add 3 to every BCD nibble that is 5 or more; nibbles never carry into each other.
   always_comb begin
      sr_adj = sr;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sr[BIN_W + 4*i +: 4] >= 4'd5)
            sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
      end
   end

   // Blank a digit only when it and every digit above it are zero; units never blank.
   always_comb begin
      logic lead;
      lead    = 1'b1;
      blank_c = '0;
      for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
         lead = lead && (sr[BIN_W + 4*(DIGITS-1-k) +: 4] == 4'd0);
         blank_c[DIGITS-1-k] = lead;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      done_n  = 1'b0;
      bcd_n   = bcd;
      blank_n = blank;
      case (state)
         IDLE: begin
            if (start) begin
               sr_n    = {BCD_W'(0), bin};
               cnt_n   = CNT_W'(BIN_W);
               state_n = ADJUST;
            end
         end
         ADJUST: begin
            sr_n    = sr_adj;
            state_n = SHIFT;
         end
         SHIFT: begin
            sr_n    = sr << 1;
            cnt_n   = cnt - CNT_W'(1);
            state_n = (cnt == CNT_W'(1)) ? FIN : ADJUST;
         end
         FIN: begin
            bcd_n   = sr[SR_W-1:BIN_W];
            blank_n = blank_c;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         blank <= BLANK_RST;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         bcd   <= bcd_n;
         blank <= blank_n;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a monitor pops on done.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  bin = '0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [11:0] bcd;
   logic [2:0]  blank;

   typedef struct {
      logic [11:0] bcd;
      logic [2:0]  blank;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   bin_to_bcd_seq #(.BIN_W(9), .DIGITS(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .bin(bin), .start(start),
      .busy(busy), .done(done), .bcd(bcd), .blank(blank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pops one expected entry per done pulse; a done with nothing queued is an error.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("bcd", 32'(bcd), 32'(e.bcd));
               chk("blank", 32'(blank), 32'(e.blank));
               chk("latency", 32'(cyc), 32'(e.due));
            end
         end
      end
   endtask

   // Called #1 after a rising edge; start is sampled by the following edge.
   task automatic do_start(input logic [8:0] v, input logic [11:0] eb, input logic [2:0] ebl,
                           input bit expect_done);
      exp_t e;
      start = 1'b1;
      bin   = v;
      if (expect_done) begin
         e.bcd = eb; e.blank = ebl; e.due = cyc + 20;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done === 1'b1) return;
         @(posedge clk); #1;
      end
      chk("done_timeout", 32'(done), 32'(1));
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [14:0] ref_conv(input int v);
      logic [3:0] d0, d1, d2;
      logic       b2, b1;
      d0 = 4'(v % 10);
      d1 = 4'((v / 10) % 10);
      d2 = 4'(v / 100);
      b2 = (d2 == 4'd0);
      b1 = b2 && (d1 == 4'd0);
      return {d2, d1, d0, b2, b1, 1'b0};
   endfunction

   initial begin
      logic [14:0] r;
      fork monitor(); join_none

      #12;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_bcd", 32'(bcd), 32'(0));
      chk("rst_blank", 32'(blank), 32'(3'b110));
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(2);

      do_start(9'd0, 12'h000, 3'b110, 1'b1);
      chk("busy_after_start", 32'(busy), 32'(1));
      wait_done(30);
      chk("busy_in_done", 32'(busy), 32'(0));
      cycles(3);
      chk("hold_bcd", 32'(bcd), 32'(12'h000));

      do_start(9'd511, 12'h511, 3'b000, 1'b1); wait_done(30); cycles(2);
      do_start(9'd100, 12'h100, 3'b000, 1'b1); wait_done(30); cycles(2);
      do_start(9'd9,   12'h009, 3'b110, 1'b1); wait_done(30); cycles(2);
      do_start(9'd10,  12'h010, 3'b100, 1'b1); wait_done(30); cycles(2);

      // Starts during busy with bin=37 must be ignored.
      do_start(9'd255, 12'h255, 3'b000, 1'b1);
      cycles(2);
      chk("busy_c3", 32'(busy), 32'(1));
      do_start(9'd37, 12'h000, 3'b000, 1'b0);
      cycles(6);
      chk("busy_c10", 32'(busy), 32'(1));
      do_start(9'd37, 12'h000, 3'b000, 1'b0);
      wait_done(30);
      cycles(25);
      chk("after_ignored_bcd", 32'(bcd), 32'(12'h255));

      // Reset mid-conversion aborts with no done.
      do_start(9'd300, 12'h000, 3'b000, 1'b0);
      cycles(7);
      rst_n = 1'b0;
      #1;
      chk("abort_bcd", 32'(bcd), 32'(0));
      chk("abort_blank", 32'(blank), 32'(3'b110));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(25);
      chk("post_abort_busy", 32'(busy), 32'(0));
      do_start(9'd42, 12'h042, 3'b100, 1'b1); wait_done(30); cycles(2);

      // Back-to-back: second start issued in the done cycle.
      do_start(9'd123, 12'h123, 3'b000, 1'b1);
      wait_done(30);
      do_start(9'd77, 12'h077, 3'b100, 1'b1);
      wait_done(30);

      // Exhaustive sweep, each start in the previous done cycle.
      for (int v = 0; v < 512; v++) begin
         r = ref_conv(v);
         do_start(9'(v), r[14:3], r[2:0], 1'b1);
         wait_done(30);
      end
      cycles(30);
      chk("queue_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
